// File: rtl/lfsr_word_gen.sv
// lfsr_word_gen: Fibonacci LFSR that packs one feedback bit per step into
// OUT_BITS-wide words and hands them out over a valid/ready handshake.
// Supports runtime reseeding. Optional all-zero lockup protection is
// enabled by defining LFSR_LOCKUP_GUARD_EN; without it a zero seed is
// loaded literally and lockup stays low.
// All outputs are driven straight from flops.
module lfsr_word_gen #(
    parameter int               WIDTH    = 16,
    parameter logic [WIDTH-1:0] TAPS     = 16'hB400,
    parameter logic [WIDTH-1:0] SEED     = 16'hACE1,
    parameter int               OUT_BITS = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                seed_load,
    input  logic [WIDTH-1:0]    seed_in,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUT_BITS-1:0] out_data,
    output logic [WIDTH-1:0]    lfsr_state,
    output logic                lockup
);

    localparam int CNT_W = (OUT_BITS > 1) ? $clog2(OUT_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_BITS - 1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // Even-parity helper: XOR of the tapped register bits.
    function automatic logic tap_parity(input logic [WIDTH-1:0] value);
        return ^(value & TAPS);
    endfunction

    state_t              state_r;
    state_t              state_nx_s;
    logic [WIDTH-1:0]    lfsr_r;
    logic [WIDTH-1:0]    lfsr_nx_s;
    logic [WIDTH-1:0]    lfsr_step_s;
    logic [OUT_BITS-1:0] col_r;
    logic [OUT_BITS-1:0] col_nx_s;
    logic [OUT_BITS-1:0] col_shift_s;
    logic [CNT_W-1:0]    cnt_r;
    logic [CNT_W-1:0]    cnt_nx_s;
    logic [OUT_BITS-1:0] out_data_r;
    logic [OUT_BITS-1:0] out_data_nx_s;
    logic                out_valid_r;
    logic                out_valid_nx_s;
    logic                lockup_r;
    logic                lockup_nx_s;
    logic                fb_s;
    logic                xfer_s;
    logic                zero_s;

    assign fb_s        = tap_parity(lfsr_r);
    assign lfsr_step_s = {lfsr_r[WIDTH-2:0], fb_s};
    assign xfer_s      = out_valid_r && out_ready;

    // The collector shift: newest bit enters at bit 0, so the first bit of a
    // word ends up in the MSB once OUT_BITS steps have been taken.
    if (OUT_BITS == 1) begin : g_col_single
        assign col_shift_s = fb_s;
    end else begin : g_col_multi
        assign col_shift_s = {col_r[OUT_BITS-2:0], fb_s};
    end

`ifdef LFSR_LOCKUP_GUARD_EN
    assign zero_s = (lfsr_r == {WIDTH{1'b0}});
`else
    assign zero_s = 1'b0;
`endif

    // Next-state logic: reseed first, then stepping/collection and handshake.
    always_comb begin
        state_nx_s     = state_r;
        lfsr_nx_s      = lfsr_r;
        col_nx_s       = col_r;
        cnt_nx_s       = cnt_r;
        out_data_nx_s  = out_data_r;
        out_valid_nx_s = out_valid_r;
        lockup_nx_s    = 1'b0;

        if (seed_load) begin
            // Reseed discards any pending word, even one being accepted now.
`ifdef LFSR_LOCKUP_GUARD_EN
            if (seed_in == {WIDTH{1'b0}}) begin
                lfsr_nx_s   = SEED;
                lockup_nx_s = 1'b1;
            end else begin
                lfsr_nx_s   = seed_in;
            end
`else
            lfsr_nx_s = seed_in;
`endif
            cnt_nx_s       = CNT_ZERO;
            col_nx_s       = {OUT_BITS{1'b0}};
            out_valid_nx_s = 1'b0;
            state_nx_s     = ST_FILL;
        end else begin
            // A consumed word drops valid unless a new word replaces it below.
            if (xfer_s) begin
                out_valid_nx_s = 1'b0;
            end else begin
                out_valid_nx_s = out_valid_r;
            end

            case (state_r)
                ST_FILL: begin
                    if (en && !zero_s) begin
                        lfsr_nx_s = lfsr_step_s;
                        col_nx_s  = col_shift_s;
                        if (cnt_r == CNT_LAST) begin
                            cnt_nx_s = CNT_ZERO;
                            if (!out_valid_r || xfer_s) begin
                                out_data_nx_s  = col_shift_s;
                                out_valid_nx_s = 1'b1;
                            end else begin
                                // Output still occupied: park the word in col.
                                state_nx_s = ST_STALL;
                            end
                        end else begin
                            cnt_nx_s = cnt_r + CNT_ONE;
                        end
                    end else begin
                        lfsr_nx_s = lfsr_r;
                    end
                end
                ST_STALL: begin
                    if (xfer_s) begin
                        out_data_nx_s  = col_r;
                        out_valid_nx_s = 1'b1;
                        state_nx_s     = ST_FILL;
                    end else begin
                        state_nx_s = ST_STALL;
                    end
                end
                default: begin
                    state_nx_s = ST_FILL;
                end
            endcase

            // Zero state recovery replaces the step; cnt and col are untouched.
            if (zero_s) begin
                lfsr_nx_s   = SEED;
                lockup_nx_s = 1'b1;
            end else begin
                lockup_nx_s = 1'b0;
            end
        end
    end

    // State, LFSR, collector and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_FILL;
            lfsr_r      <= SEED;
            col_r       <= {OUT_BITS{1'b0}};
            cnt_r       <= CNT_ZERO;
            out_data_r  <= {OUT_BITS{1'b0}};
            out_valid_r <= 1'b0;
            lockup_r    <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            lfsr_r      <= lfsr_nx_s;
            col_r       <= col_nx_s;
            cnt_r       <= cnt_nx_s;
            out_data_r  <= out_data_nx_s;
            out_valid_r <= out_valid_nx_s;
            lockup_r    <= lockup_nx_s;
        end
    end

    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign lfsr_state = lfsr_r;
    assign lockup     = lockup_r;

endmodule

// File: tb/tb_lfsr_word_gen.sv
// Directed testbench for lfsr_word_gen with default parameters
// (WIDTH=16, TAPS=16'hB400, SEED=16'hACE1, OUT_BITS=4).
module tb_lfsr_word_gen;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_data;
    logic [15:0] lfsr_state;
    logic        lockup;

    int tests_run;
    int tests_failed;

    // Hand-computed LFSR states after enabled steps 1..12 from 16'hACE1.
    logic [15:0] exp_state [12] = '{16'h59C3, 16'hB387, 16'h670F, 16'hCE1E,
                                    16'h9C3C, 16'h3879, 16'h70F2, 16'hE1E4,
                                    16'hC3C8, 16'h8791, 16'h0F22, 16'h1E45};
    // Hand-computed first three words.
    logic [3:0]  exp_word [3] = '{4'hE, 4'h4, 4'h5};

    lfsr_word_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .en         (en),
        .seed_load  (seed_load),
        .seed_in    (seed_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .lfsr_state (lfsr_state),
        .lockup     (lockup)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        en        = 1'b0;
        seed_load = 1'b0;
        seed_in   = 16'h0000;
        out_ready = 1'b0;
        reset_n   = 1'b0;
        #2;
        reset_n   = 1'b1;
    endtask

    task automatic test_reset();
        tick();
        en = 1'b1; out_ready = 1'b1;
        tick();
        reset_n = 1'b0;
        #2;
        tests_run++;
        if (lfsr_state !== 16'hACE1) begin
            tests_failed++; $display("FAIL reset_lfsr got %h want ACE1", lfsr_state);
        end
        tests_run++;
        if (out_valid !== 1'b0 || out_data !== 4'h0 || lockup !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_outputs got valid=%b data=%h lockup=%b want 0/0/0",
                     out_valid, out_data, lockup);
        end
        apply_reset();
        tick();
        tests_run++;
        if (lfsr_state !== 16'hACE1) begin
            tests_failed++; $display("FAIL en_low_freeze got %h want ACE1", lfsr_state);
        end
    endtask

    task automatic test_sequence();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            tests_run++;
            if (lfsr_state !== exp_state[i-1]) begin
                tests_failed++;
                $display("FAIL seq_state step %0d got %h want %h", i, lfsr_state, exp_state[i-1]);
            end
            tests_run++;
            if (out_valid !== ((i % 4) == 0)) begin
                tests_failed++;
                $display("FAIL seq_valid step %0d got %b want %b", i, out_valid, (i % 4) == 0);
            end
            if ((i % 4) == 0) begin
                tests_run++;
                if (out_data !== exp_word[i/4-1]) begin
                    tests_failed++;
                    $display("FAIL seq_word step %0d got %h want %h", i, out_data, exp_word[i/4-1]);
                end
            end
        end
    endtask

    task automatic test_stall();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        for (int i = 5; i <= 10; i++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_data !== 4'hE) begin
                tests_failed++;
                $display("FAIL stall_hold cyc %0d got valid=%b data=%h want 1/E", i, out_valid, out_data);
            end
            tests_run++;
            if (lfsr_state !== exp_state[(i > 8) ? 7 : i-1]) begin
                tests_failed++;
                $display("FAIL stall_state cyc %0d got %h want %h", i, lfsr_state,
                         exp_state[(i > 8) ? 7 : i-1]);
            end
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 4'h4 || lfsr_state !== 16'hE1E4) begin
            tests_failed++;
            $display("FAIL stall_release got valid=%b data=%h lfsr=%h want 1/4/E1E4",
                     out_valid, out_data, lfsr_state);
        end
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (lfsr_state !== 16'h1E45 || out_data !== 4'h4 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_resume got lfsr=%h data=%h valid=%b want 1E45/4/1",
                     lfsr_state, out_data, out_valid);
        end
    endtask

    task automatic test_seed_load();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        out_ready = 1'b0;
        tick();
        tick();
        seed_load = 1'b1; seed_in = 16'h0001; out_ready = 1'b1;
        tick();
        seed_load = 1'b0;
        tests_run++;
        if (lfsr_state !== 16'h0001 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL seed_load got lfsr=%h valid=%b want 0001/0", lfsr_state, out_valid);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests_run++;
            if (out_valid !== (i == 4)) begin
                tests_failed++;
                $display("FAIL seed_latency step %0d got valid=%b want %b", i, out_valid, i == 4);
            end
        end
        tests_run++;
        if (lfsr_state !== 16'h0010 || out_data !== 4'h0) begin
            tests_failed++;
            $display("FAIL seed_word got lfsr=%h data=%h want 0010/0", lfsr_state, out_data);
        end
    endtask

    task automatic test_zero_seed();
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
`ifdef LFSR_LOCKUP_GUARD_EN
        tests_run++;
        if (lfsr_state !== 16'hACE1 || lockup !== 1'b1) begin
            tests_failed++;
            $display("FAIL zero_seed_guard got lfsr=%h lockup=%b want ACE1/1", lfsr_state, lockup);
        end
        tick();
        tests_run++;
        if (lfsr_state !== 16'h59C3 || lockup !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_seed_pulse got lfsr=%h lockup=%b want 59C3/0", lfsr_state, lockup);
        end
`else
        tests_run++;
        if (lfsr_state !== 16'h0000 || lockup !== 1'b0) begin
            tests_failed++;
            $display("FAIL zero_seed_load got lfsr=%h lockup=%b want 0000/0", lfsr_state, lockup);
        end
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (lfsr_state !== 16'h0000 || out_valid !== 1'b1 || out_data !== 4'h0) begin
            tests_failed++;
            $display("FAIL zero_seed_word got lfsr=%h valid=%b data=%h want 0000/1/0",
                     lfsr_state, out_valid, out_data);
        end
`endif
    endtask

    task automatic test_en_toggle();
        apply_reset();
        out_ready = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            en = ((i % 2) == 1);
            tick();
            tests_run++;
            if (out_valid !== ((i % 8) == 7)) begin
                tests_failed++;
                $display("FAIL toggle_valid cyc %0d got %b want %b", i, out_valid, (i % 8) == 7);
            end
            if ((i % 8) == 7) begin
                tests_run++;
                if (out_data !== exp_word[i/8]) begin
                    tests_failed++;
                    $display("FAIL toggle_word cyc %0d got %h want %h", i, out_data, exp_word[i/8]);
                end
            end
        end
        tests_run++;
        if (lfsr_state !== 16'h1E45) begin
            tests_failed++; $display("FAIL toggle_state got %h want 1E45", lfsr_state);
        end
    endtask

    task automatic test_period();
        int zero_seen;
        int early_repeat;
        zero_seen = 0;
        early_repeat = 0;
        apply_reset();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 65535; i++) begin
            tick();
            if (lfsr_state == 16'h0000) zero_seen++;
            if (i < 65535 && lfsr_state == 16'hACE1) early_repeat++;
        end
        tests_run++;
        if (lfsr_state !== 16'hACE1) begin
            tests_failed++; $display("FAIL period_end got %h want ACE1", lfsr_state);
        end
        tests_run++;
        if (zero_seen != 0 || early_repeat != 0) begin
            tests_failed++;
            $display("FAIL period_path got zero=%0d early=%0d want 0/0", zero_seen, early_repeat);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        apply_reset();
        test_reset();
        test_sequence();
        test_stall();
        test_seed_load();
        test_zero_seed();
        test_en_toggle();
        test_period();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lfsr_word_gen.md
# lfsr_word_gen

Parametrised Fibonacci LFSR pseudo-random generator. It packs one feedback bit per step into OUT_BITS-wide words and delivers them over a valid/ready handshake. It supports runtime reseeding and all-zero lockup protection. It sits between the game timing logic and the note/lane scheduler, replacing the fixed 12-bit single-bit generator as the source of random lane selection.

## Interface
Parameters:
- WIDTH, 16: LFSR register width, 3..32.
- TAPS, 16'hB400: feedback tap mask, WIDTH bits. Bit i set means lfsr[i] feeds the XOR. Default is maximal length (x^16+x^14+x^13+x^11).
- SEED, 16'hACE1: reset and recovery value. Must be non-zero.
- OUT_BITS, 4: output word width, 1..WIDTH.

Ports:
- clk, input, 1: sole clock, rising edge.
- reset_n, input, 1: asynchronous, active-low reset.
- en, input, 1: step enable. Low freezes the LFSR and the collector.
- seed_load, input, 1: synchronous reseed strobe.
- seed_in, input, WIDTH: value loaded on seed_load.
- out_ready, input, 1: consumer accepts out_data.
- out_valid, output, 1: out_data holds an unconsumed word.
- out_data, output, OUT_BITS: random word.
- lfsr_state, output, WIDTH: current LFSR register.
- lockup, output, 1: one-cycle pulse when a zero state was corrected.

## Operation
- Feedback: fb = XOR-reduce(lfsr & TAPS). Step: lfsr <= {lfsr[WIDTH-2:0], fb}.
- Collector: a shift register col plus a step counter cnt in 0..OUT_BITS-1. Each step shifts fb into col bit 0, so the first bit of a word lands in the MSB.
- FSM states:
  - FILL: on each cycle with en=1, step. On the step where cnt==OUT_BITS-1, form the word {col[OUT_BITS-2:0], fb}.
    - If the output register is free, or is being consumed this cycle (out_valid && out_ready), load the word into out_data, set out_valid=1, clear cnt, stay in FILL.
    - Otherwise keep the completed word in col and go to STALL.
  - STALL: the LFSR does not step. When out_valid && out_ready, move col to out_data, keep out_valid=1, go to FILL.
- Handshake: a word transfers on any cycle with out_valid && out_ready. out_valid then drops on the next edge unless a new word loads on that same edge. out_data is stable while out_valid && !out_ready.
- en=0: no step and no FSM advance. The handshake still completes, and STALL→FILL still occurs.
- seed_load=1 has priority over stepping and the handshake:
  - lfsr <= seed_in, cnt <= 0, col <= 0, out_valid <= 0, FSM <= FILL.
  - A pending word is discarded, even if out_ready is high the same cycle.
- Reset values: lfsr=SEED, col=0, cnt=0, out_valid=0, out_data=0, lockup=0, FSM=FILL.

## Timing
- Reset deassertion is asynchronous into the flops. The first step occurs on the first rising edge with reset_n=1 and en=1.
- Latency: out_valid rises on the OUT_BITS-th enabled step edge after reset or seed_load.
- Sustained throughput: one word per OUT_BITS enabled cycles when out_ready is held high. There are no bubbles beyond the fill time.
- lfsr_state and lockup are registered outputs. There is no combinational path from any input to any output.
- Period: 2^WIDTH-1 steps with maximal taps.

## Configuration
- LFSR_LOCKUP_GUARD_EN defined:
  - seed_load with seed_in==0 loads SEED instead and pulses lockup.
  - Any cycle with lfsr==0 (e.g. upset) reloads SEED on the next edge in place of a step and pulses lockup. cnt and col are kept.
- Undefined:
  - Zero is loaded literally. The LFSR stays at zero and words are all zeros.
  - lockup is tied to 0.

## Test plan
- Reset, en=1, out_ready=1, defaults:
  - lfsr_state sequence is ACE1, 59C3, B387, 670F, CE1E.
  - out_valid=1 with out_data=4'hE after the 4th edge.
- out_ready held low after the first word: out_data holds 4'hE. Four more steps fill col, then STALL freezes lfsr_state. Raising out_ready for one cycle transfers and resumes stepping.
- Run 65535 enabled steps from SEED: lfsr_state returns to 16'hACE1 and never equals 0 in between.
- seed_load with seed_in=16'h0001 mid-fill while out_valid=1 and out_ready=1: next cycle lfsr_state=0001, out_valid=0, and the first word appears 4 steps later.
- seed_load with seed_in=0:
  - Guard defined: lfsr_state=ACE1 and lockup=1 for exactly one cycle.
  - Guard undefined: lfsr_state stays 0 and out_data=0.
- Toggle en every other cycle: the word sequence is identical to the en=1 run, and out_valid timing stretches to 8 cycles per word.
